// File: rtl/spi_ram_master.sv
// -----------------------------------------------------------------------------
// spi_ram_master
//
// Initiator side of the SPI RAM link. Turns parallel command requests into
// SS_n/MOSI frames for the SPI slave + RAM wrapper and returns the bytes read
// back on MISO. The master and the slave share the system clock, so one bit
// moves per clk and there is no SCLK.
//
// Frame layout (SS_n low):
//   START   1 clk       MOSI = op[1] (sampled by the slave's command-check cycle)
//   TX      10 clks     MOSI = {op, data}, MSB first
//   WAIT_RD RD_LAT clks MOSI = 0 (op 11 only)
//   RX      8 clks      MISO captured MSB first (op 11 only)
// Ops 00/01/10 hold SS_n low for 11 clks, op 11 for 19+RD_LAT clks.
// Between frames SS_n stays high for at least GAP clks. With cmd_valid held
// high, the next START begins GAP+1 clks after END.
//
// Parameters:
//   RD_LAT  clks from the last MOSI payload bit to the first valid MISO bit
//   GAP     minimum clks SS_n stays high between frames (>= 1)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  command can be accepted (idle and inter-frame gap elapsed)
//   cmd_op     00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data   address or data byte (sent as-is for op 11)
//   rsp_valid  one-clk pulse when rsp_data holds the byte of an op-11 frame
//   rsp_data   last captured MISO byte, held until the next op-11 capture
//   busy       high from command accept until SS_n returns high
//   SS_n       slave select, active low
//   MOSI       serial data to slave, MSB first
//   MISO       serial data from slave, MSB first
// -----------------------------------------------------------------------------
module spi_ram_master #(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TX,
        S_WAIT_RD,
        S_RX,
        S_END
    } state_t;

    localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

    state_t        state;
    logic [9:0]    shift_q;   // {op, data}, bit 9 goes out next
    logic [3:0]    bit_cnt;   // TX: 9..0, RX: 7..0
    logic [WW-1:0] wait_cnt;  // WAIT_RD: RD_LAT-1..0
    logic [GW-1:0] gap_left;  // clks of SS_n-high still owed before cmd_ready
    logic [6:0]    rx_q;      // first 7 MISO bits; the 8th goes straight to rsp_data
    logic          rd_frame;  // current frame is an op-11 read

    // NOTE: every register below is assigned with <= so all next-state values
    // are computed from the same pre-edge snapshot of the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            cmd_ready <= 1'b1;
            shift_q   <= '0;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            gap_left  <= '0;
            rx_q      <= '0;
            rd_frame  <= 1'b0;
        end else begin
            // NOTE: rsp_valid defaults low every clk so the RX branch can only
            // raise it for a single cycle.
            rsp_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        shift_q   <= {cmd_op, cmd_data};
                        rd_frame  <= (cmd_op == 2'b11);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        SS_n      <= 1'b0;
                        MOSI      <= cmd_op[1];
                        state     <= S_START;
                    end else if (!cmd_ready) begin
                        if (gap_left <= GW'(1)) begin
                            cmd_ready <= 1'b1;
                        end else begin
                            gap_left <= gap_left - 1'b1;
                        end
                    end
                end

                S_START: begin
                    MOSI    <= shift_q[9];
                    shift_q <= {shift_q[8:0], 1'b0};
                    bit_cnt <= 4'd9;
                    state   <= S_TX;
                end

                S_TX: begin
                    if (bit_cnt == 4'd0) begin
                        MOSI <= 1'b0;
                        if (rd_frame) begin
                            if (RD_LAT == 0) begin
                                bit_cnt <= 4'd7;
                                state   <= S_RX;
                            end else begin
                                wait_cnt <= WW'(RD_LAT - 1);
                                state    <= S_WAIT_RD;
                            end
                        end else begin
                            SS_n     <= 1'b1;
                            busy     <= 1'b0;
                            gap_left <= GW'(GAP);
                            state    <= S_END;
                        end
                    end else begin
                        MOSI    <= shift_q[9];
                        shift_q <= {shift_q[8:0], 1'b0};
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                S_WAIT_RD: begin
                    if (wait_cnt == '0) begin
                        bit_cnt <= 4'd7;
                        state   <= S_RX;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                S_RX: begin
                    rx_q <= {rx_q[5:0], MISO};
                    if (bit_cnt == 4'd0) begin
                        rsp_data  <= {rx_q, MISO};
                        rsp_valid <= 1'b1;
                        SS_n      <= 1'b1;
                        busy      <= 1'b0;
                        gap_left  <= GW'(GAP);
                        state     <= S_END;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end

                S_END: begin
                    // The END clk itself is the first clk of the gap.
                    state <= S_IDLE;
                    if (gap_left <= GW'(1)) begin
                        cmd_ready <= 1'b1;
                    end else begin
                        gap_left <= gap_left - 1'b1;
                    end
                end

                default: begin
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_master.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_master
//
// Directed + randomized bench for spi_ram_master. A behavioural slave on the
// negative edge decodes each SS_n frame, keeps its own RAM and returns read
// bytes on MISO. Expected frames and read data come from a command-level
// model in the main sequence (RAM array + write/read address registers).
// -----------------------------------------------------------------------------
module tb_spi_ram_master;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;
    localparam int RD_LEN = 19 + RD_LAT;
    localparam int MAXF   = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       MISO = 1'b0;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;

    spi_ram_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural slave / frame monitor ----------------
    int          frames = 0;
    int          rsp_pulses = 0;
    int          mosi_idle_bad = 0;
    int          mosi_wait_bad = 0;
    int          f_len [MAXF];
    logic [10:0] f_bits[MAXF];
    int          f_gap [MAXF];
    logic [7:0]  sram  [256];
    logic [7:0]  s_wa = 8'h00;
    logic [7:0]  s_ra = 8'h00;
    bit          in_frame = 1'b0;
    int          idx = 0;
    int          high_cnt = 0;
    logic [10:0] cur_bits = '0;
    logic [7:0]  rd_byte = 8'h00;

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 8'h00;
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_pulses++;
        if (SS_n === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                idx      = 0;
                cur_bits = '0;
                if (frames < MAXF) f_gap[frames] = high_cnt;
            end
            if (idx <= 10) cur_bits = {cur_bits[9:0], MOSI};
            else if (idx < 11 + RD_LAT && MOSI !== 1'b0) mosi_wait_bad++;
            if (idx == 10 && cur_bits[9:8] == 2'b11) rd_byte = sram[s_ra];
            if (idx >= 11 + RD_LAT && idx < RD_LEN && cur_bits[9:8] == 2'b11)
                MISO = rd_byte[7 - (idx - 11 - RD_LAT)];
            else
                MISO = 1'($urandom);
            idx++;
            high_cnt = 0;
        end else begin
            if (MOSI !== 1'b0) mosi_idle_bad++;
            high_cnt++;
            MISO = 1'($urandom);
            if (in_frame) begin
                in_frame = 1'b0;
                if (frames < MAXF) begin
                    f_len[frames]  = idx;
                    f_bits[frames] = cur_bits;
                end
                if (idx == 11 || idx == RD_LEN) begin
                    case (cur_bits[9:8])
                        2'b00:   s_wa = cur_bits[7:0];
                        2'b01:   sram[s_wa] = cur_bits[7:0];
                        2'b10:   s_ra = cur_bits[7:0];
                        default: ;
                    endcase
                end
                frames++;
            end
        end
    end

    // ---------------- command-level reference model ----------------
    logic [7:0]  exp_ram[256];
    logic [7:0]  m_wa = 8'h00;
    logic [7:0]  m_ra = 8'h00;
    logic [7:0]  m_last_rsp = 8'h00;
    int          exp_pulses = 0;
    int          exp_frames = 0;
    int          done_upto = 0;
    int          e_len [MAXF];
    logic [10:0] e_bits[MAXF];

    // Present a command, wait for it to be accepted, record the expected frame.
    // Caller is always just after a rising edge.
    task automatic present(input logic [1:0] op, input logic [7:0] data,
                           input bit apply, input bit hold);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", 32'(n < 100), 32'd1);
        @(posedge clk); #1;
        check("accept_ready_low", 32'(cmd_ready), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        if (!hold) begin
            cmd_valid = 1'b0;
            cmd_op    = 2'($urandom);
            cmd_data  = 8'($urandom);
        end
        if (exp_frames < MAXF) begin
            e_len[exp_frames]  = (op == 2'b11) ? RD_LEN : 11;
            e_bits[exp_frames] = {op[1], op, data};
        end
        exp_frames++;
        if (apply) begin
            case (op)
                2'b00: m_wa = data;
                2'b01: exp_ram[m_wa] = data;
                2'b10: m_ra = data;
                default: begin
                    m_last_rsp = exp_ram[m_ra];
                    exp_pulses++;
                end
            endcase
        end
    endtask

    // Wait for all expected frames to close and compare them.
    task automatic drain();
        int n = 0;
        while (frames < exp_frames && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("frame_timeout", 32'(n < 500), 32'd1);
        for (int i = done_upto; i < exp_frames && i < MAXF; i++) begin
            check("frame_len", 32'(f_len[i]), 32'(e_len[i]));
            check("frame_bits", 32'(f_bits[i]), 32'(e_bits[i]));
            if (i > 0) check("gap_min", 32'(f_gap[i] >= GAP + 1), 32'd1);
        end
        done_upto = exp_frames;
        check("rsp_pulses", 32'(rsp_pulses), 32'(exp_pulses));
        check("rsp_data", 32'(rsp_data), 32'(m_last_rsp));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 256; i++) exp_ram[i] = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ss_n", 32'(SS_n), 32'd1);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;

        // 1: reset mid-TX of an op-01 frame aborts it (no RAM write, no rsp)
        present(2'b01, 8'h5A, 1'b0, 1'b0);
        e_len[exp_frames - 1]  = 5;
        e_bits[exp_frames - 1] = e_bits[exp_frames - 1] >> 6;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_ss_n", 32'(SS_n), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        drain();

        // 2..4: write 0xA5 to 0x3C, then read it back
        present(2'b00, 8'h3C, 1'b1, 1'b0);
        drain();
        present(2'b01, 8'hA5, 1'b1, 1'b0);
        drain();
        present(2'b10, 8'h3C, 1'b1, 1'b0);
        present(2'b11, 8'($urandom), 1'b1, 1'b0);
        drain();
        check("read_back_a5", 32'(rsp_data), 32'h0000_00A5);

        // 5: back-to-back with cmd_valid held: SS_n high GAP+1 clks between frames
        k = exp_frames;
        present(2'b00, 8'h11, 1'b1, 1'b1);
        present(2'b01, 8'h77, 1'b1, 1'b1);
        present(2'b00, 8'h3C, 1'b1, 1'b0);
        drain();
        check("b2b_gap1", 32'(f_gap[k + 1]), 32'(GAP + 1));
        check("b2b_gap2", 32'(f_gap[k + 2]), 32'(GAP + 1));

        // 6: cmd_valid pulsed while busy is ignored
        present(2'b10, 8'h11, 1'b1, 1'b0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 8'hEE;
        @(posedge clk); #1;
        check("busy_ready_low", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        drain();
        repeat (30) begin @(posedge clk); #1; end
        check("no_extra_frame", 32'(frames), 32'(exp_frames));
        present(2'b11, 8'h00, 1'b1, 1'b0);
        drain();
        check("read_back_77", 32'(rsp_data), 32'h0000_0077);

        // Randomized command stream over a small address window
        for (int t = 0; t < 20; t++) begin
            logic [1:0] op;
            logic [7:0] d;
            op = 2'($urandom);
            d  = (op[0] == 1'b0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            present(op, d, 1'b1, 1'b0);
            drain();
        end

        check("mosi_idle_zero", 32'(mosi_idle_bad), 32'd0);
        check("mosi_wait_zero", 32'(mosi_wait_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
